// File: rtl/mul_accumulator.sv
// Signed product accumulator: sums a group of 64-bit products into an ACC_W-bit
// register, then presents sum, count and a sticky overflow flag until taken.
module mul_accumulator #(
   parameter int ACC_W = 72,
   parameter int CNT_W = 16
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    prod_valid,
   output logic                    prod_ready,
   input  logic signed [63:0]      product,
   input  logic                    prod_last,
   output logic                    acc_valid,
   input  logic                    acc_ready,
   output logic signed [ACC_W-1:0] acc_sum,
   output logic [CNT_W-1:0]        acc_count,
   output logic                    acc_ovf
);

   typedef enum logic {
      ST_ACCUM  = 1'b0,
      ST_OUTPUT = 1'b1
   } state_t;

   state_t                  state_p0;
   state_t                  state_nxt;
   logic signed [ACC_W-1:0] sum_p0;
   logic [CNT_W-1:0]        cnt_p0;
   logic                    ovf_p0;
   logic signed [ACC_W-1:0] prod_ext;
   logic signed [ACC_W-1:0] sum_add;
   logic                    prod_xfer;
   logic                    acc_xfer;

   function automatic logic signed [ACC_W-1:0] sext_prod(input logic signed [63:0] p);
      logic signed [ACC_W-1:0] r;
      r = p;
      return r;
   endfunction

   function automatic logic add_ovf(input logic signed [ACC_W-1:0] a,
                                    input logic signed [ACC_W-1:0] b,
                                    input logic signed [ACC_W-1:0] s);
      return (a[ACC_W-1] == b[ACC_W-1]) && (s[ACC_W-1] != a[ACC_W-1]);
   endfunction

   // Count saturates at all-ones rather than wrapping back to zero.
   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
      return (&c) ? c : c + CNT_W'(1);
   endfunction

   assign prod_xfer = prod_valid & prod_ready;
   assign acc_xfer  = acc_valid & acc_ready;
   assign prod_ext  = sext_prod(product);
   assign sum_add   = sum_p0 + prod_ext;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_p0 <= ST_ACCUM;
      end else begin
         state_p0 <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state_p0;
      case (state_p0)
         ST_ACCUM:  if (prod_valid && prod_last) state_nxt = ST_OUTPUT;
         ST_OUTPUT: if (acc_ready) state_nxt = ST_ACCUM;
         default:   state_nxt = ST_ACCUM;
      endcase
   end

   always_comb begin
      prod_ready = 1'b0;
      acc_valid  = 1'b0;
      case (state_p0)
         ST_ACCUM:  prod_ready = 1'b1;
         ST_OUTPUT: acc_valid  = 1'b1;
         default:   prod_ready = 1'b0;
      endcase
   end

   // Accumulator stage: group state clears on reset or on result handshake.
   always_ff @(posedge clk) begin
      if (rst || acc_xfer) begin
         sum_p0 <= '0;
         cnt_p0 <= '0;
         ovf_p0 <= 1'b0;
      end else if (prod_xfer) begin
         sum_p0 <= sum_add;
         cnt_p0 <= sat_inc(cnt_p0);
         ovf_p0 <= ovf_p0 | add_ovf(sum_p0, prod_ext, sum_add);
      end
   end

   assign acc_sum   = sum_p0;
   assign acc_count = cnt_p0;
   assign acc_ovf   = ovf_p0;

endmodule
